// File: rtl/flop_pkg.sv
// Shared definitions for the flop cell family.
package flop_pkg;

    // Widest register a single flopenr instance may hold.
    localparam int FLOP_MAX_WIDTH = 64;

    // Value type of one stored bit.
    typedef logic flop_word_t;

    // True when a requested register width is supported.
    function automatic bit flop_width_ok(input int width);
        return (width >= 1) && (width <= FLOP_MAX_WIDTH);
    endfunction

endpackage : flop_pkg

// File: rtl/flopenr_cell.sv
// Single-bit D flop with load enable and asynchronous active-high reset.
module flopenr_cell
    import flop_pkg::*;
#(
    parameter flop_word_t RESET_VAL = 1'b0
) (
    input  logic ph1,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    logic r_q;

    // Reset wins over enable; otherwise load d when enabled, else hold.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : flopenr_cell

// File: rtl/flopenr.sv
// WIDTH-bit enabled register with asynchronous active-high reset to RESET_VAL.
module flopenr
    import flop_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reject unsupported widths at elaboration.
    if (!flop_width_ok(WIDTH)) begin : g_bad_width
        $fatal(1, "flopenr: WIDTH=%0d outside 1..%0d", WIDTH, FLOP_MAX_WIDTH);
    end

    logic [WIDTH-1:0] w_q;

    // One cell per bit, all sharing the clock, reset and enable.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        flopenr_cell #(
            .RESET_VAL (RESET_VAL[gi])
        ) u_cell (
            .ph1   (ph1),
            .reset (reset),
            .en    (en),
            .d     (d[gi]),
            .q     (w_q[gi])
        );
    end

    assign q = w_q;

endmodule : flopenr

// File: tb/tb_flopenr.sv
// Directed bench for flopenr: a 1-bit instance on a timed sequence and an
// 8-bit instance (reset value 8'hA5) driven from a vector table.
module tb_flopenr;

    logic       ph1;
    logic       rst1, en1, d1;
    logic       q1;
    logic       rst8, en8;
    logic [7:0] d8, q8;

    int total = 0;
    int bad   = 0;

    flopenr #(.WIDTH(1)) u_dut1 (
        .ph1   (ph1),
        .reset (rst1),
        .en    (en1),
        .d     (d1),
        .q     (q1)
    );

    flopenr #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
        .ph1   (ph1),
        .reset (rst8),
        .en    (en8),
        .d     (d8),
        .q     (q8)
    );

    // 10 ns period, rising edges at 1, 11, 21, ... ns.
    initial begin
        ph1 = 1'b0;
        #1;
        forever begin
            ph1 = 1'b1;
            #5;
            ph1 = 1'b0;
            #5;
        end
    end

    // Absolute guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic wait_until(input time t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        vecs[0] = '{rst: 1'b1, en: 1'b1, d: 8'hFF, exp: 8'hA5};
        vecs[1] = '{rst: 1'b0, en: 1'b1, d: 8'h3C, exp: 8'h3C};
        vecs[2] = '{rst: 1'b0, en: 1'b0, d: 8'hFF, exp: 8'h3C};
        vecs[3] = '{rst: 1'b0, en: 1'b0, d: 8'h00, exp: 8'h3C};
        vecs[4] = '{rst: 1'b0, en: 1'b1, d: 8'hFF, exp: 8'hFF};
        vecs[5] = '{rst: 1'b0, en: 1'b1, d: 8'h00, exp: 8'h00};
        vecs[6] = '{rst: 1'b1, en: 1'b0, d: 8'h3C, exp: 8'hA5};
        vecs[7] = '{rst: 1'b0, en: 1'b0, d: 8'h3C, exp: 8'hA5};
        vecs[8] = '{rst: 1'b0, en: 1'b1, d: 8'h5A, exp: 8'h5A};
        vecs[9] = '{rst: 1'b0, en: 1'b1, d: 8'h81, exp: 8'h81};

        rst1 = 1'b1; en1 = 1'b1; d1 = 1'b1;
        rst8 = 1'b1; en8 = 1'b1; d8 = 8'hFF;

        // Reset held across the edges at 1 and 11 ns.
        wait_until(5);
        check("rst_hold1_a", {7'd0, q1}, 8'h00);
        check("rst_hold8_a", q8, 8'hA5);
        wait_until(15);
        check("rst_hold1_b", {7'd0, q1}, 8'h00);
        check("rst_hold8_b", q8, 8'hA5);

        // Release, then load 0 at 21 ns and 1 at 31 ns.
        wait_until(17);
        rst1 = 1'b0; d1 = 1'b0; en1 = 1'b1;
        rst8 = 1'b0; en8 = 1'b0;
        wait_until(22);
        check("load0", {7'd0, q1}, 8'h00);
        d1 = 1'b1;
        wait_until(33);
        check("load1", {7'd0, q1}, 8'h01);

        // Hold with enable low while d toggles.
        wait_until(37);
        en1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_until(42 + 10 * k);
            d1 = ~d1;
            wait_until(44 + 10 * k);
            check("hold_en0", {7'd0, q1}, 8'h01);
        end

        // Enable again: q follows d at the next edge.
        wait_until(138);
        en1 = 1'b1; d1 = 1'b0;
        wait_until(143);
        check("reenable0", {7'd0, q1}, 8'h00);
        wait_until(144);
        d1 = 1'b1;
        wait_until(153);
        en1 = 1'b0;
        check("reenable1", {7'd0, q1}, 8'h01);

        // Asynchronous reset pulse between edges while holding.
        wait_until(155);
        rst1 = 1'b1;
        wait_until(156);
        check("async_in_pulse", {7'd0, q1}, 8'h00);
        wait_until(157);
        rst1 = 1'b0;
        wait_until(159);
        check("async_after", {7'd0, q1}, 8'h00);
        wait_until(163);
        check("async_no_en_edge", {7'd0, q1}, 8'h00);
        wait_until(165);
        en1 = 1'b1; d1 = 1'b1;
        wait_until(173);
        check("post_async_load", {7'd0, q1}, 8'h01);

        // Reset priority over enable across an edge.
        wait_until(175);
        rst1 = 1'b1;
        wait_until(183);
        check("rst_priority1", {7'd0, q1}, 8'h00);
        wait_until(185);
        rst1 = 1'b0; en1 = 1'b0;
        check("wide_idle_hold", q8, 8'hA5);

        // Wide instance: one vector per cycle, driven on the falling edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge ph1);
            rst8 = vecs[i].rst; en8 = vecs[i].en; d8 = vecs[i].d;
            #1;
            if (vecs[i].rst) check("wide_async", q8, 8'hA5);
            @(posedge ph1);
            #2;
            check($sformatf("wide_vec%0d", i), q8, vecs[i].exp);
        end

        // Enable pulse that ends before the edge has no effect.
        @(negedge ph1);
        d8 = 8'h11; en8 = 1'b1;
        #2;
        en8 = 1'b0;
        @(posedge ph1);
        #2;
        check("en_glitch_hold", q8, 8'h81);

        // Load 3C, then present FF with enable low: 3C is kept.
        @(negedge ph1);
        d8 = 8'h3C; en8 = 1'b1;
        @(posedge ph1);
        #2;
        check("wide_load", q8, 8'h3C);
        @(negedge ph1);
        d8 = 8'hFF; en8 = 1'b0;
        repeat (3) @(posedge ph1);
        #2;
        check("wide_held", q8, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_flopenr
